// File: rtl/nibble_serial_logic_ctrl_pkg.sv
// Shared op and state codes for the nibble-serial logic sequencer.
// Imported by four_bit_logic and nibble_serial_logic_ctrl.
package nibble_serial_logic_ctrl_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // One latched operation: everything captured when start is accepted.
    typedef struct packed {
        logic [1:0] op;
    } req_t;

endpackage

// File: rtl/nibble_serial_logic_ctrl_four_bit_logic.sv
// Combinational 4-bit logic slice shared across all nibbles of an operand.
// b is don't-care for NOT.
module four_bit_logic
    import nibble_serial_logic_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [3:0] out
);

    always_comb begin
        out = 4'h0;
        case (op)
            OP_NOT: out = ~a;
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
        endcase
    end

endmodule

// File: rtl/nibble_serial_logic_ctrl.sv
// Nibble-serial 32-bit logic unit: one 4-bit slice, one nibble per clock, LSB first.
// Optional result-is-zero flag enabled by defining ZERO_FLAG_EN.
module nibble_serial_logic_ctrl
    import nibble_serial_logic_ctrl_pkg::*;
#(
    parameter int NIBBLES = 8,
    parameter int CNT_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [4*NIBBLES-1:0] out,
    output logic                 busy,
    output logic                 done,
    output logic                 zero
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    req_t                      req_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   shadow;
    logic [NIBBLES-1:0][3:0]   result;
    logic [3:0]                slice_out;
    logic                      finish;

    four_bit_logic u_slice (
        .a   (a_q[cnt]),
        .b   (b_q[cnt]),
        .op  (req_q.op),
        .out (slice_out)
    );

    // Shadow with the current nibble merged in; this is what lands on out at the final nibble.
    always_comb begin
        result      = shadow;
        result[cnt] = slice_out;
    end

    assign finish = (state == S_RUN) && !abort && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            req_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            shadow <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        req_q.op <= op;
                        shadow   <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == LAST) begin
                        out   <= result;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        shadow[cnt] <= slice_out;
                        cnt         <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ZERO_FLAG_EN
    // Updated only alongside out, so it always describes the visible result.
    always_ff @(posedge clk) begin
        if (!rst_n)
            zero <= 1'b0;
        else if (finish)
            zero <= (result == '0);
    end
`else
    assign zero = 1'b0;
`endif

endmodule
